pio_out_timed: RTL and testbench
================================

Name: pio_out_timed

Overview:
Parametrised successor to the single-bit Avalon-MM output PIO used for peripheral reset and control lines, such as the OLED reset.
- Drives a WIDTH-bit output port from a memory-mapped data register.
- Adds atomic SET/CLEAR access and a hardware-timed pulse engine, so the CPU can generate exact-length reset or strobe pulses without software delay loops.
- Sits on the SOPC Avalon-MM bus as a zero-wait-state slave.

Parameters:
- WIDTH, 8, output port width (1..32)
- RESET_VALUE, 0, value of the data register and out_port after reset
- CNT_W, 16, pulse-length counter width (1..32)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- address  in  3  register word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  combinational read data
- out_port  out  WIDTH  driven output lines
- busy  out  1  pulse engine active
- irq  out  1  present only with PIO_IRQ_EN

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port named reset.
- Write enable: wr = chipselect & ~write_n. Reads are combinational, 0 latency, with no read strobe side effects. Unused readdata bits read 0.
- Register map:
  - 0 DATA (RW): data <= wd[WIDTH-1:0].
  - 1 SET (W; reads return data): data <= data | wd.
  - 2 CLEAR (W; reads return data): data <= data & ~wd.
  - 3 PMASK (RW, WIDTH bits): bits inverted during a pulse.
  - 4 PLEN (RW, CNT_W bits): pulse length in clk cycles.
  - 5 CTRL/STATUS:
    - write bit0=1 starts a pulse.
    - write bit1=1 clears done.
    - read bit0=busy, bit1=done (sticky), bit2=irq_en (0 without macro).
  - 6, 7: reads return 0; writes are ignored.
- FSM states: IDLE, ACTIVE.
  - IDLE, start written, PLEN!=0: latch mask_q<=PMASK, cnt<=PLEN, go to ACTIVE next edge.
  - IDLE, start written, PLEN==0: no pulse; done<=1 on the same edge.
  - ACTIVE: cnt decrements each cycle. When cnt==1: go to IDLE and set done.
  - Pulse duration: out_port is inverted for exactly PLEN cycles, beginning the cycle after the start write.
  - Start while ACTIVE: ignored. No retrigger, and done is unchanged.
- out_port = data ^ (ACTIVE ? mask_q : 0), registered-state based with no combinational bus path. busy = (state==ACTIVE).
- DATA/SET/CLEAR writes during ACTIVE take effect immediately; the inversion still applies on top.
- PMASK/PLEN writes during ACTIVE do not affect the running pulse; they apply to the next start.
- Same-edge start-write completion with a done-clear write: impossible, since CTRL is a single register. If one CTRL write has both bit0 and bit1 set, the clear applies first and the start is then processed. This means done=1 at the same edge if PLEN==0.
- Pulse completing on the same edge as a done-clear write: set wins, so done=1.
- Reset values: data=RESET_VALUE, out_port=RESET_VALUE, PMASK=0, PLEN=0, state=IDLE, cnt=0, done=0, busy=0, irq=0, irq_en=0.
- Reset mid-pulse: asynchronous abort to IDLE. No done is flagged.

Optional Feature:
PIO_IRQ_EN.
- Defined: CTRL bit2 is an RW irq_en, and irq = done & irq_en, registered-state based. irq clears when done is cleared via CTRL bit1.
- Undefined: no irq port, CTRL bit2 reads 0 and writes are ignored. All other behaviour is identical.

Decomposition:
- Package pio_out_timed_pkg holds:
  - address constants ADDR_DATA=0, ADDR_SET=1, ADDR_CLR=2, ADDR_PMASK=3, ADDR_PLEN=4, ADDR_CTRL=5
  - CTRL bit indices START=0, DONE_CLR=1, IRQ_EN=2
  - state enum {IDLE, ACTIVE}
- Sub-module pio_pulse_timer: owns the FSM, cnt, mask_q, done and busy. The top level keeps the register file and the read mux.

Test Plan:
- Reset check: WIDTH=8, RESET_VALUE=8'hA5, assert reset asynchronously mid-cycle -> out_port=8'hA5 immediately; readdata@0=32'h000000A5; busy=0.
- Bit access: write DATA=8'h0F, SET 8'hF0, CLEAR 8'h81 -> out_port goes 0F, FF, 7E on successive edges; reads of addr 1 and 2 return the current data.
- Timed pulse: DATA=8'h00, PMASK=8'h01, PLEN=5, CTRL=1 -> out_port[0]=1 for exactly 5 cycles starting the next cycle; busy high for those 5 cycles; then STATUS=32'h2.
- Start ignored: start again at cycle 2 of a PLEN=10 pulse -> pulse still ends at cycle 10. Start with PLEN=0 -> no toggle, done=1 on the same edge.
- Mid-pulse reset: assert reset at cycle 3 of a PLEN=8 pulse -> out_port returns to RESET_VALUE asynchronously; after release STATUS=0 and no further toggling.
- IRQ (PIO_IRQ_EN): CTRL=4 then start PLEN=3 -> irq rises with done after 3 cycles; write CTRL=2 -> irq and done fall next edge. Without the macro, CTRL bit2 reads 0.

Source files
------------

// File: rtl/pio_out_timed_pkg.sv
// Shared constants and types for the timed output PIO: register addresses,
// CTRL bit positions and the pulse-engine state encoding.
package pio_out_timed_pkg;

  localparam logic [2:0] ADDR_DATA  = 3'd0;
  localparam logic [2:0] ADDR_SET   = 3'd1;
  localparam logic [2:0] ADDR_CLR   = 3'd2;
  localparam logic [2:0] ADDR_PMASK = 3'd3;
  localparam logic [2:0] ADDR_PLEN  = 3'd4;
  localparam logic [2:0] ADDR_CTRL  = 3'd5;

  localparam int START    = 0;
  localparam int DONE_CLR = 1;
  localparam int IRQ_EN   = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/pio_out_timed_pulse_timer.sv
// Pulse engine: counts a latched length down while presenting a latched
// inversion mask, and raises a sticky done flag when the pulse ends.
module pio_pulse_timer
  import pio_out_timed_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             done_clr_i,
  input  logic [WIDTH-1:0] pmask_i,
  input  logic [CNT_W-1:0] plen_i,
  output logic [WIDTH-1:0] pulse_mask_o,
  output logic             busy_o,
  output logic             done_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             done_q, done_d;
  logic             last_s;
  logic             plen_zero_s;

  assign last_s      = (cnt_q == CNT_W'(1));
  assign plen_zero_s = (plen_i == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i && !plen_zero_s) state_d = ACTIVE; else state_d = IDLE;
      ACTIVE:  if (last_s) state_d = IDLE; else state_d = ACTIVE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      mask_q <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mask_q <= mask_d;
      done_q <= done_d;
    end
  end

  // Clear is applied before any set so a completing pulse or a zero-length
  // start always leaves done high.
  always_comb begin
    cnt_d  = cnt_q;
    mask_d = mask_q;
    done_d = done_q;
    if (done_clr_i) done_d = 1'b0; else done_d = done_q;
    case (state_q)
      IDLE: begin
        if (start_i && !plen_zero_s) begin
          cnt_d  = plen_i;
          mask_d = pmask_i;
        end else if (start_i) begin
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      ACTIVE: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (last_s) done_d = 1'b1; else done_d = done_d;
      end
      default: cnt_d = '0;
    endcase
  end

  always_comb begin
    busy_o       = (state_q == ACTIVE);
    pulse_mask_o = busy_o ? mask_q : '0;
    done_o       = done_q;
  end

endmodule

// File: rtl/pio_out_timed.sv
// Avalon-MM output PIO with SET/CLEAR access and a hardware-timed pulse engine.
// Define PIO_IRQ_EN to add the irq port and the CTRL irq_en bit.
module pio_out_timed
  import pio_out_timed_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             busy
`ifdef PIO_IRQ_EN
  ,
  output logic             irq
`endif
);

  logic             wr_s;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] pmask_q, pmask_d;
  logic [CNT_W-1:0] plen_q, plen_d;
  logic             irq_en_q;
  logic             start_s, done_clr_s, done_s;
  logic [WIDTH-1:0] pulse_mask_s;
  logic             unused_wd;

  assign wr_s       = chipselect & ~write_n;
  assign start_s    = wr_s && (address == ADDR_CTRL) && writedata[START];
  assign done_clr_s = wr_s && (address == ADDR_CTRL) && writedata[DONE_CLR];
  assign unused_wd  = ^writedata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= RESET_VALUE;
      pmask_q <= '0;
      plen_q  <= '0;
    end else begin
      data_q  <= data_d;
      pmask_q <= pmask_d;
      plen_q  <= plen_d;
    end
  end

  always_comb begin
    data_d  = data_q;
    pmask_d = pmask_q;
    plen_d  = plen_q;
    if (wr_s) begin
      case (address)
        ADDR_DATA:  data_d  = writedata[WIDTH-1:0];
        ADDR_SET:   data_d  = data_q | writedata[WIDTH-1:0];
        ADDR_CLR:   data_d  = data_q & ~writedata[WIDTH-1:0];
        ADDR_PMASK: pmask_d = writedata[WIDTH-1:0];
        ADDR_PLEN:  plen_d  = writedata[CNT_W-1:0];
        default:    data_d  = data_q;
      endcase
    end else begin
      data_d = data_q;
    end
  end

`ifdef PIO_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             irq_en_q <= 1'b0;
    else if (wr_s && address == ADDR_CTRL) irq_en_q <= writedata[IRQ_EN];
    else                                   irq_en_q <= irq_en_q;
  end

  assign irq = done_s & irq_en_q;
`else
  assign irq_en_q = 1'b0;
`endif

  pio_pulse_timer #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_timer (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_s),
    .done_clr_i   (done_clr_s),
    .pmask_i      (pmask_q),
    .plen_i       (plen_q),
    .pulse_mask_o (pulse_mask_s),
    .busy_o       (busy),
    .done_o       (done_s)
  );

  assign out_port = data_q ^ pulse_mask_s;

  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_DATA, ADDR_SET, ADDR_CLR: readdata[WIDTH-1:0] = data_q;
      ADDR_PMASK: readdata[WIDTH-1:0] = pmask_q;
      ADDR_PLEN:  readdata[CNT_W-1:0] = plen_q;
      ADDR_CTRL:  readdata[2:0]       = {irq_en_q, done_s, busy};
      default:    readdata            = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_pio_out_timed.sv
// Self-checking bench for pio_out_timed: register vector table plus
// hand-written pulse, retrigger, reset and irq sequences.
module tb_pio_out_timed;
  import pio_out_timed_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        busy;
`ifdef PIO_IRQ_EN
  logic        irq;
`endif

  int total = 0;
  int bad = 0;

  pio_out_timed #(.WIDTH(8), .RESET_VALUE(8'hA5), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .busy       (busy)
`ifdef PIO_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    int          sel;
    logic [31:0] v;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wd;
    logic [2:0]  raddr;
    logic [7:0]  eout;
    logic [31:0] erd;
  } vec_t;
  vec_t vt[11];

  function automatic logic [31:0] probe(int sel);
    case (sel)
      0: return {24'd0, out_port};
      1: return readdata;
      2: return {31'd0, busy};
`ifdef PIO_IRQ_EN
      3: return {31'd0, irq};
`endif
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_v(string nm, int sel, logic [31:0] v);
    sbq.push_back('{nm, sel, v});
  endtask

  task automatic drain();
    while (sbq.size() > 0) begin
      exp_t        e;
      logic [31:0] a;
      e = sbq.pop_front();
      a = probe(e.sel);
      total++;
      if (a !== e.v) begin
        bad++;
        $display("FAIL %s: got %h expected %h", e.nm, a, e.v);
      end
    end
  endtask

  task automatic bus_write(logic [2:0] a, logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
  endtask

  task automatic read_chk(string nm, logic [2:0] a, logic [31:0] v);
    address = a;
    #1;
    expect_v(nm, 1, v);
    drain();
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vt[0]  = '{1'b1, ADDR_DATA,  32'h0000_000F, ADDR_DATA,  8'h0F, 32'h0000_000F};
    vt[1]  = '{1'b1, ADDR_SET,   32'h0000_00F0, ADDR_SET,   8'hFF, 32'h0000_00FF};
    vt[2]  = '{1'b1, ADDR_CLR,   32'h0000_0081, ADDR_CLR,   8'h7E, 32'h0000_007E};
    vt[3]  = '{1'b0, ADDR_DATA,  32'h0000_0055, ADDR_DATA,  8'h7E, 32'h0000_007E};
    vt[4]  = '{1'b1, ADDR_PMASK, 32'h0000_003C, ADDR_PMASK, 8'h7E, 32'h0000_003C};
    vt[5]  = '{1'b1, ADDR_PMASK, 32'h0000_0101, ADDR_PMASK, 8'h7E, 32'h0000_0001};
    vt[6]  = '{1'b1, ADDR_PLEN,  32'h0001_2345, ADDR_PLEN,  8'h7E, 32'h0000_2345};
    vt[7]  = '{1'b1, 3'd6,       32'hFFFF_FFFF, 3'd6,       8'h7E, 32'h0000_0000};
    vt[8]  = '{1'b1, 3'd7,       32'hFFFF_FFFF, 3'd7,       8'h7E, 32'h0000_0000};
    vt[9]  = '{1'b1, ADDR_DATA,  32'hFFFF_FF00, ADDR_DATA,  8'h00, 32'h0000_0000};
    vt[10] = '{1'b1, ADDR_CTRL,  32'h0000_0002, ADDR_CTRL,  8'h00, 32'h0000_0000};

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    expect_v("reset out_port", 0, 32'h0000_00A5);
    expect_v("reset busy", 2, 32'd0);
    drain();
    read_chk("reset data", ADDR_DATA, 32'h0000_00A5);
    read_chk("reset pmask", ADDR_PMASK, 32'd0);
    read_chk("reset plen", ADDR_PLEN, 32'd0);
    read_chk("reset status", ADDR_CTRL, 32'd0);

    for (int i = 0; i < 11; i++) begin
      if (vt[i].we) begin
        bus_write(vt[i].addr, vt[i].wd);
      end else begin
        @(negedge clk);
        address = vt[i].addr; chipselect = 1'b1; write_n = 1'b1; writedata = vt[i].wd;
        cycle();
        chipselect = 1'b0;
      end
      expect_v($sformatf("vec%0d out_port", i), 0, {24'd0, vt[i].eout});
      drain();
      read_chk($sformatf("vec%0d readdata", i), vt[i].raddr, vt[i].erd);
    end

    // Basic timed pulse: 5 cycles of inversion on bit 0.
    bus_write(ADDR_PMASK, 32'h01);
    bus_write(ADDR_PLEN, 32'd5);
    bus_write(ADDR_CTRL, 32'h1);
    for (int i = 0; i < 7; i++) begin
      expect_v($sformatf("pulse out c%0d", i), 0, (i < 5) ? 32'h1 : 32'h0);
      expect_v($sformatf("pulse busy c%0d", i), 2, (i < 5) ? 32'h1 : 32'h0);
      drain();
      if (i < 6) cycle();
    end
    read_chk("pulse status", ADDR_CTRL, 32'h2);

    // Retrigger ignored and PMASK changed mid-pulse.
    bus_write(ADDR_PLEN, 32'd10);
    bus_write(ADDR_CTRL, 32'h2);
    bus_write(ADDR_CTRL, 32'h1);
    bus_write(ADDR_CTRL, 32'h1);
    bus_write(ADDR_PMASK, 32'h80);
    for (int i = 2; i < 12; i++) begin
      expect_v($sformatf("retrig out c%0d", i), 0, (i < 10) ? 32'h1 : 32'h0);
      expect_v($sformatf("retrig busy c%0d", i), 2, (i < 10) ? 32'h1 : 32'h0);
      drain();
      if (i < 11) cycle();
    end
    read_chk("retrig status", ADDR_CTRL, 32'h2);

    // Zero-length start: done on the same edge, no toggle.
    bus_write(ADDR_PLEN, 32'd0);
    bus_write(ADDR_CTRL, 32'h2);
    read_chk("plen0 cleared", ADDR_CTRL, 32'h0);
    bus_write(ADDR_CTRL, 32'h1);
    expect_v("plen0 out", 0, 32'h0);
    expect_v("plen0 busy", 2, 32'h0);
    drain();
    read_chk("plen0 status", ADDR_CTRL, 32'h2);
    bus_write(ADDR_CTRL, 32'h2);
    read_chk("clr status", ADDR_CTRL, 32'h0);
    bus_write(ADDR_CTRL, 32'h3);
    read_chk("clr+start status", ADDR_CTRL, 32'h2);

    // Done-clear landing on the completion edge: set wins.
    bus_write(ADDR_PLEN, 32'd2);
    bus_write(ADDR_CTRL, 32'h2);
    bus_write(ADDR_CTRL, 32'h1);
    expect_v("setwin busy0", 2, 32'h1);
    drain();
    bus_write(3'd7, 32'h0);
    bus_write(ADDR_CTRL, 32'h2);
    expect_v("setwin busy2", 2, 32'h0);
    drain();
    read_chk("setwin status", ADDR_CTRL, 32'h2);

    // Asynchronous reset in the third cycle of an 8-cycle pulse.
    bus_write(ADDR_PLEN, 32'd8);
    bus_write(ADDR_CTRL, 32'h1);
    cycle();
    cycle();
    expect_v("midrst pre out", 0, 32'h80);
    drain();
    address = ADDR_DATA;
    #2;
    reset = 1'b1;
    #1;
    expect_v("midrst out", 0, 32'hA5);
    expect_v("midrst busy", 2, 32'h0);
    expect_v("midrst data", 1, 32'hA5);
    drain();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      expect_v($sformatf("postrst out c%0d", i), 0, 32'hA5);
      drain();
    end
    read_chk("postrst status", ADDR_CTRL, 32'h0);

`ifdef PIO_IRQ_EN
    bus_write(ADDR_CTRL, 32'h4);
    read_chk("irq_en status", ADDR_CTRL, 32'h4);
    bus_write(ADDR_PMASK, 32'h01);
    bus_write(ADDR_PLEN, 32'd3);
    bus_write(ADDR_CTRL, 32'h5);
    for (int i = 0; i < 5; i++) begin
      expect_v($sformatf("irq c%0d", i), 3, (i >= 3) ? 32'h1 : 32'h0);
      drain();
      if (i < 4) cycle();
    end
    bus_write(ADDR_CTRL, 32'h2);
    expect_v("irq cleared", 3, 32'h0);
    drain();
    read_chk("irq status", ADDR_CTRL, 32'h0);
`else
    bus_write(ADDR_CTRL, 32'h4);
    read_chk("no irq_en bit", ADDR_CTRL, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
